mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 55 +++++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared memory-access definitions: arbiter state encoding, funct3 access-mode
// constants, and the lane-select / legality helpers used by the arbiter and by
// any cpudefs consumer that decodes load/store widths.
// Ports: none (package).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        RMW_WRITE = 2'd2
    } memState_t;

    // funct3 encodings; loads and stores share the width field
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Unsigned variants only exist for loads.
    function automatic logic isBadMode(input logic [2:0] mode, input logic write);
        case (mode)
            FUNCT3_B, FUNCT3_H, FUNCT3_W: return 1'b0;
            FUNCT3_BU, FUNCT3_HU:         return write;
            default:                      return 1'b1;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] mode, input logic [1:0] lowAddr);
        case (mode)
            FUNCT3_H, FUNCT3_HU: return lowAddr[0];
            FUNCT3_W:            return (lowAddr != 2'b00);
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] selectByte(input logic [31:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    function automatic logic [15:0] selectHalf(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

    function automatic logic [31:0] wordAlign(input logic [31:0] address);
        return {address[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Combinational byte/half lane handling for a 32-bit word memory.
// Ports:
//   address    [1:0]  byte offset within the word
//   mode       [2:0]  funct3 access width / signedness
//   wordIn     [31:0] word read from memory
//   storeData  [31:0] store operand (low bytes used for SB/SH)
//   loadValue  [31:0] extracted, sign/zero-extended load result
//   mergedWord [31:0] wordIn with the addressed lane replaced by storeData
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  address,
    input  logic [2:0]  mode,
    input  logic [31:0] wordIn,
    input  logic [31:0] storeData,
    output logic [31:0] loadValue,
    output logic [31:0] mergedWord
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = selectByte(wordIn, address);
        halfVal = selectHalf(wordIn, address[1]);

        loadValue = '0;
        case (mode)
            FUNCT3_B:  loadValue = {{24{byteVal[7]}}, byteVal};
            FUNCT3_H:  loadValue = {{16{halfVal[15]}}, halfVal};
            FUNCT3_W:  loadValue = wordIn;
            FUNCT3_BU: loadValue = {24'd0, byteVal};
            FUNCT3_HU: loadValue = {16'd0, halfVal};
            default:   loadValue = '0;
        endcase

        mergedWord = wordIn;
        case (mode)
            FUNCT3_B: mergedWord[{address, 3'b000} +: 8] = storeData[7:0];
            FUNCT3_H: begin
                if (address[1]) mergedWord[31:16] = storeData[15:0];
                else            mergedWord[15:0]  = storeData[15:0];
            end
            FUNCT3_W: mergedWord = storeData;
            default:  mergedWord = wordIn;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port and a data load/store port onto a single
// combinational-read, word-write memory. Sub-word stores are done as a
// read-modify-write. Misaligned and illegal-mode data accesses complete without
// touching memory and report a flag in the ready cycle.
//
// Build option: MEM_ARBITER_ROUND_ROBIN_EN -- when defined, simultaneous
// requests alternate between ports (instruction first after reset); otherwise
// data has fixed priority over instruction.
//
// Ports:
//   i_Clock, i_Reset_n                 clock (rising edge), async active-low reset
//   i_IReq, i_IAddress                 instruction fetch request
//   o_IReady, o_IData                  fetch completion pulse and word
//   i_DReq, i_DWrite, i_DAddress,
//   i_DData, i_DMode                   data request, direction, address, store data, funct3
//   o_DReady, o_DData,
//   o_DMisaligned, o_DBadMode          data completion pulse, load value, error flags
//   o_MemWriteEnable, o_MemReadEnable,
//   o_MemAddress, o_MemDataIn          memory control, word address, write data
//   i_MemDataOut                       memory read data (same cycle)
//
// state     | meaning
// IDLE      | no access; grants a requester unless a ready pulse is out this cycle
// ACCESS    | read or full-word write of the registered request, or error completion
// RMW_WRITE | write back the merged word of an SB/SH
module mem_arbiter
    import mem_pkg::*;
(
    input  logic        i_Clock,
    input  logic        i_Reset_n,

    input  logic        i_IReq,
    input  logic [31:0] i_IAddress,
    output logic        o_IReady,
    output logic [31:0] o_IData,

    input  logic        i_DReq,
    input  logic        i_DWrite,
    input  logic [31:0] i_DAddress,
    input  logic [31:0] i_DData,
    input  logic [2:0]  i_DMode,
    output logic        o_DReady,
    output logic [31:0] o_DData,
    output logic        o_DMisaligned,
    output logic        o_DBadMode,

    output logic        o_MemWriteEnable,
    output logic        o_MemReadEnable,
    output logic [31:0] o_MemAddress,
    output logic [31:0] o_MemDataIn,
    input  logic [31:0] i_MemDataOut
);

    memState_t   state, nextState;

    logic        curIsData;
    logic        curWrite;
    logic [31:0] curAddress;
    logic [31:0] curWData;
    logic [2:0]  curMode;
    logic        curMisaligned;
    logic        curBadMode;
    logic [31:0] mergedReg;

    logic        dEligible, iEligible, pickData, grantValid, curError;
    logic        selBad, selMis;
    logic [31:0] loadValue, mergedWord;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic        lastWasData;
`endif

    mem_lane_align u_laneAlign (
        .address    (curAddress[1:0]),
        .mode       (curMode),
        .wordIn     (i_MemDataOut),
        .storeData  (curWData),
        .loadValue  (loadValue),
        .mergedWord (mergedWord)
    );

    // A requester still holds its request during its own ready cycle, so that
    // cycle never grants. This also means one port cannot immediately re-win
    // in a way that hides the other's request from round-robin.
    always_comb begin
        dEligible = i_DReq & ~o_DReady;
        iEligible = i_IReq & ~o_IReady;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (dEligible && iEligible) pickData = ~lastWasData;
        else                        pickData = dEligible;
`else
        pickData = dEligible;
`endif
        grantValid = (state == IDLE) && !(o_IReady || o_DReady) && (dEligible || iEligible);
        selBad     = pickData & isBadMode(i_DMode, i_DWrite);
        selMis     = pickData & ~selBad & isMisaligned(i_DMode, i_DAddress[1:0]);
        curError   = curMisaligned | curBadMode;
    end

    always_comb begin
        nextState        = state;
        o_MemWriteEnable = 1'b0;
        o_MemReadEnable  = 1'b0;
        o_MemAddress     = '0;
        o_MemDataIn      = '0;
        case (state)
            IDLE: begin
                if (grantValid) nextState = ACCESS;
            end
            ACCESS: begin
                nextState = IDLE;
                if (!curError) begin
                    o_MemAddress = wordAlign(curAddress);
                    if (curWrite && (curMode == FUNCT3_W)) begin
                        o_MemWriteEnable = 1'b1;
                        o_MemDataIn      = curWData;
                    end else begin
                        o_MemReadEnable = 1'b1;
                        if (curWrite) nextState = RMW_WRITE;
                    end
                end
            end
            RMW_WRITE: begin
                nextState        = IDLE;
                o_MemWriteEnable = 1'b1;
                o_MemAddress     = wordAlign(curAddress);
                o_MemDataIn      = mergedReg;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state         <= IDLE;
            curIsData     <= 1'b0;
            curWrite      <= 1'b0;
            curAddress    <= '0;
            curWData      <= '0;
            curMode       <= '0;
            curMisaligned <= 1'b0;
            curBadMode    <= 1'b0;
            mergedReg     <= '0;
            o_IReady      <= 1'b0;
            o_IData       <= '0;
            o_DReady      <= 1'b0;
            o_DData       <= '0;
            o_DMisaligned <= 1'b0;
            o_DBadMode    <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            lastWasData   <= 1'b1;
`endif
        end else begin
            state         <= nextState;
            o_IReady      <= 1'b0;
            o_DReady      <= 1'b0;
            o_DMisaligned <= 1'b0;
            o_DBadMode    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        curIsData     <= pickData;
                        curWrite      <= pickData & i_DWrite;
                        curAddress    <= pickData ? i_DAddress : i_IAddress;
                        curWData      <= i_DData;
                        curMode       <= pickData ? i_DMode : FUNCT3_W;
                        curMisaligned <= selMis;
                        curBadMode    <= selBad;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        lastWasData   <= pickData;
`endif
                    end
                end
                ACCESS: begin
                    if (!curIsData) begin
                        o_IReady <= 1'b1;
                        o_IData  <= i_MemDataOut;
                    end else if (curError) begin
                        o_DReady      <= 1'b1;
                        o_DData       <= '0;
                        o_DMisaligned <= curMisaligned;
                        o_DBadMode    <= curBadMode;
                    end else if (curWrite) begin
                        if (curMode == FUNCT3_W) begin
                            o_DReady <= 1'b1;
                            o_DData  <= '0;
                        end else begin
                            mergedReg <= mergedWord;
                        end
                    end else begin
                        o_DReady <= 1'b1;
                        o_DData  <= loadValue;
                    end
                end
                RMW_WRITE: begin
                    o_DReady <= 1'b1;
                    o_DData  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected
// responses and memory writes into queues; monitors on the falling edge pop
// and compare whenever the DUT presents a ready pulse or a memory write.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        iReq = 1'b0;
    logic [31:0] iAddr = '0;
    logic        iReady;
    logic [31:0] iData;
    logic        dReq = 1'b0, dWrite = 1'b0;
    logic [31:0] dAddr = '0, dWData = '0;
    logic [2:0]  dMode = '0;
    logic        dReady, dMis, dBad;
    logic [31:0] dRData;
    logic        memWe, memRe;
    logic [31:0] memAddr, memDin, memDout;

    logic [31:0] mem [0:1023];
    logic        preWe = 1'b0;
    logic [9:0]  preIdx = '0;
    logic [31:0] preData = '0;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int readCount = 0;
    int writeCount = 0;
    int bothEnables = 0;
    int spuriousFlags = 0;
    logic [31:0] lastReadAddr = '0;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        bad;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    resp_t iQ[$];
    resp_t dQ[$];
    wr_t   wQ[$];

    mem_arbiter dut (
        .i_Clock          (clk),
        .i_Reset_n        (rstN),
        .i_IReq           (iReq),
        .i_IAddress       (iAddr),
        .o_IReady         (iReady),
        .o_IData          (iData),
        .i_DReq           (dReq),
        .i_DWrite         (dWrite),
        .i_DAddress       (dAddr),
        .i_DData          (dWData),
        .i_DMode          (dMode),
        .o_DReady         (dReady),
        .o_DData          (dRData),
        .o_DMisaligned    (dMis),
        .o_DBadMode       (dBad),
        .o_MemWriteEnable (memWe),
        .o_MemReadEnable  (memRe),
        .o_MemAddress     (memAddr),
        .o_MemDataIn      (memDin),
        .i_MemDataOut     (memDout)
    );

    always #5 clk = ~clk;

    assign memDout = mem[memAddr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memWe)      mem[memAddr[11:2]] <= memDin;
        else if (preWe) mem[preIdx] <= preData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Response and memory-side monitors.
    always @(negedge clk) begin
        resp_t e;
        wr_t   w;
        if (memWe && memRe) bothEnables++;
        if (!dReady && (dMis || dBad)) spuriousFlags++;
        if (memRe) begin
            readCount++;
            lastReadAddr = memAddr;
        end
        if (memWe) begin
            writeCount++;
            if (wQ.size() == 0) check("unexpectedWrite", memAddr, 32'hFFFF_FFFF);
            else begin
                w = wQ.pop_front();
                check("wrAddr", memAddr, w.addr);
                check("wrData", memDin, w.data);
                check("wrCycle", 32'(cyc), 32'(w.cyc));
            end
        end
        if (iReady) begin
            if (iQ.size() == 0) check("unexpectedIReady", iData, 32'hFFFF_FFFF);
            else begin
                e = iQ.pop_front();
                check("iData", iData, e.data);
                check("iCycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (dReady) begin
            if (dQ.size() == 0) check("unexpectedDReady", dRData, 32'hFFFF_FFFF);
            else begin
                e = dQ.pop_front();
                check("dData", dRData, e.data);
                check("dFlags", {30'd0, dMis, dBad}, {30'd0, e.mis, e.bad});
                check("dCycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        preWe = 1'b1;
        preIdx = addr[11:2];
        preData = data;
        @(posedge clk); #1;
        preWe = 1'b0;
    endtask

    task automatic waitReady(input logic isData, input string name);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if ((isData && dReady) || (!isData && iReady)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s: actual=no ready required=ready within 20 cycles", name);
        end
    endtask

    task automatic doI(input logic [31:0] addr, input logic [31:0] expData);
        int r0 = readCount;
        int w0 = writeCount;
        iQ.push_back('{expData, 1'b0, 1'b0, cyc + 2});
        iReq = 1'b1;
        iAddr = addr;
        waitReady(1'b0, "iTimeout");
        iReq = 1'b0;
        check("iReads", 32'(readCount - r0), 32'd1);
        check("iWrites", 32'(writeCount - w0), 32'd0);
        check("iReadAddr", lastReadAddr, {addr[31:2], 2'b00});
        @(posedge clk); #1;
    endtask

    task automatic doD(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] mode, input logic [31:0] expData,
                       input logic expMis, input logic expBad, input int lat,
                       input int expReads, input int expWrites,
                       input logic [31:0] expWData, input int wrLat);
        int r0 = readCount;
        int w0 = writeCount;
        dQ.push_back('{expData, expMis, expBad, cyc + lat});
        if (expWrites > 0) wQ.push_back('{{addr[31:2], 2'b00}, expWData, cyc + wrLat});
        dReq = 1'b1;
        dWrite = wr;
        dAddr = addr;
        dWData = wdata;
        dMode = mode;
        waitReady(1'b1, "dTimeout");
        dReq = 1'b0;
        check("dReads", 32'(readCount - r0), 32'(expReads));
        check("dWrites", 32'(writeCount - w0), 32'(expWrites));
        @(posedge clk); #1;
    endtask

    function automatic logic anyOutput();
        return |{iReady, iData, dReady, dRData, dMis, dBad, memWe, memRe, memAddr, memDin};
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("resetOutputs", 32'(anyOutput()), 32'd0);
        rstN = 1'b1;
        preload(32'h0000_0104, 32'hDEAD_BEEF);
        preload(32'h0000_0200, 32'h1122_3344);
        @(posedge clk); #1;

        doI(32'h0000_0104, 32'hDEAD_BEEF);
        // SB 0xAA into byte 1: read at N+1, write at N+2, ready at N+3
        doD(1'b1, 32'h0000_0201, 32'h0000_00AA, FUNCT3_B,  32'h0, 0, 0, 3, 1, 1, 32'h1122_AA44, 2);
        doD(1'b0, 32'h0000_0201, 32'h0,         FUNCT3_B,  32'hFFFF_FFAA, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0201, 32'h0,         FUNCT3_BU, 32'h0000_00AA, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0202, 32'h0,         FUNCT3_W,  32'h0, 1, 0, 2, 0, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0200, 32'h0,         3'b011,    32'h0, 0, 1, 2, 0, 0, 32'h0, 0);
        doD(1'b1, 32'h0000_0200, 32'h0000_0055, FUNCT3_BU, 32'h0, 0, 1, 2, 0, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0202, 32'h0,         FUNCT3_H,  32'h0000_1122, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0200, 32'h0,         FUNCT3_H,  32'hFFFF_AA44, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0200, 32'h0,         FUNCT3_HU, 32'h0000_AA44, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b1, 32'h0000_0300, 32'h5566_7788, FUNCT3_W,  32'h0, 0, 0, 2, 0, 1, 32'h5566_7788, 1);
        doD(1'b1, 32'h0000_0302, 32'h0000_BEEF, FUNCT3_H,  32'h0, 0, 0, 3, 1, 1, 32'hBEEF_7788, 2);
        doD(1'b0, 32'h0000_0300, 32'h0,         FUNCT3_W,  32'hBEEF_7788, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0303, 32'h0,         FUNCT3_B,  32'hFFFF_FFBE, 0, 0, 2, 1, 0, 32'h0, 0);
        doD(1'b0, 32'h0000_0301, 32'h0,         FUNCT3_HU, 32'h0, 1, 0, 2, 0, 0, 32'h0, 0);
        doD(1'b1, 32'h0000_0303, 32'h0000_1234, FUNCT3_H,  32'h0, 1, 0, 2, 0, 0, 32'h0, 0);
        doD(1'b1, 32'h0000_0301, 32'h0000_1234, FUNCT3_W,  32'h0, 1, 0, 2, 0, 0, 32'h0, 0);

        // Reset while the SH write-back is pending: the word must survive.
        dReq = 1'b1; dWrite = 1'b1; dAddr = 32'h0000_0200; dWData = 32'h0000_1234; dMode = FUNCT3_H;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rmwPendingWe", 32'(memWe), 32'd1);
        rstN = 1'b0;
        #1;
        check("rmwResetOutputs", 32'(anyOutput()), 32'd0);
        dReq = 1'b0; dWrite = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rmwResetHold", 32'(anyOutput()), 32'd0);
        check("rmwWordKept", mem[10'h080], 32'h1122_AA44);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Both ports held continuously from the first cycle after reset.
        n = cyc;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        iQ.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, n + 2});
        dQ.push_back('{32'hBEEF_7788, 1'b0, 1'b0, n + 5});
        iQ.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, n + 8});
`else
        dQ.push_back('{32'hBEEF_7788, 1'b0, 1'b0, n + 2});
        dQ.push_back('{32'hBEEF_7788, 1'b0, 1'b0, n + 5});
        dQ.push_back('{32'hBEEF_7788, 1'b0, 1'b0, n + 8});
`endif
        iReq = 1'b1; iAddr = 32'h0000_0104;
        dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h0000_0300; dMode = FUNCT3_W;
        repeat (9) begin
            @(posedge clk); #1;
        end
        iReq = 1'b0; dReq = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end

        doD(1'b0, 32'h0000_0200, 32'h0, FUNCT3_W, 32'h1122_AA44, 0, 0, 2, 1, 0, 32'h0, 0);

        check("iQueueEmpty", 32'(iQ.size()), 32'd0);
        check("dQueueEmpty", 32'(dQ.size()), 32'd0);
        check("wQueueEmpty", 32'(wQ.size()), 32'd0);
        check("bothEnables", 32'(bothEnables), 32'd0);
        check("spuriousFlags", 32'(spuriousFlags), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
